// File: rtl/bisr_pkg.sv
// -----------------------------------------------------------------------------
// bisr_pkg
//  Definitions shared by the BISR blocks (the fault-scan priority encoder and
//  the spare index decoder):
//   - state_e        : decoder handshake FSM states (IDLE / HOLD / FULL)
//   - ENC_IDX_LSB    : bit position of the index field inside an encoded code
//   - enc_active_pos : bit position of the ACTIVE flag (always the MSB of the code)
//   - bisr_clog2     : ceiling log2, kept here so the encoder and the decoder
//                      size their code fields identically
// -----------------------------------------------------------------------------
package bisr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_FULL = 2'd2
    } state_e;

    // The index field sits at the bottom of the code, the ACTIVE flag on top.
    localparam int ENC_IDX_LSB = 0;

    function automatic int bisr_clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

    function automatic int enc_active_pos(input int output_width);
        return bisr_clog2(output_width);
    endfunction

endpackage

// File: rtl/index_onehot_decoder.sv
// -----------------------------------------------------------------------------
// index_onehot_decoder
//  Pure combinational index -> one-hot decoder with an out-of-range flag.
//  Parameters:
//   OUTPUT_WIDTH : number of lanes decoded (>= 2)
//   DECODED_VAL  : value driven on the selected lane; all other lanes get the
//                  inverse
//   IDX_W        : index width, defaults to clog2(OUTPUT_WIDTH)
//  Ports:
//   idx_i       in   IDX_W          lane index
//   onehot_o    out  OUTPUT_WIDTH   one-hot select, polarity DECODED_VAL
//   range_err_o out  1              idx_i >= OUTPUT_WIDTH (no lane selected)
// -----------------------------------------------------------------------------
module index_onehot_decoder
    import bisr_pkg::*;
#(
    parameter int OUTPUT_WIDTH = 4,
    parameter bit DECODED_VAL  = 1'b1,
    parameter int IDX_W        = bisr_clog2(OUTPUT_WIDTH)
) (
    input  logic [IDX_W-1:0]        idx_i,
    output logic [OUTPUT_WIDTH-1:0] onehot_o,
    output logic                    range_err_o
);

    genvar gi;
    generate
        for (gi = 0; gi < OUTPUT_WIDTH; gi++) begin : g_lane
            assign onehot_o[gi] = (idx_i == IDX_W'(gi)) ? DECODED_VAL : ~DECODED_VAL;
        end
    endgenerate

    // One extra bit so that OUTPUT_WIDTH itself is representable for
    // power-of-two widths (where the flag can never assert).
    assign range_err_o = ({1'b0, idx_i} >= (IDX_W + 1)'(OUTPUT_WIDTH));

endmodule

// File: rtl/spare_index_decoder.sv
// -----------------------------------------------------------------------------
// spare_index_decoder
//  Inverse of the BISR priority encoder. Takes {active, idx} codes through a
//  valid/ready handshake, turns each accepted active code into a registered
//  one-hot spare/faulty PE select and accumulates every claimed lane in an
//  allocation map for the remap logic.
//
//  Parameters:
//   OUTPUT_WIDTH      number of PE/spare lanes (>= 2)
//   DECODED_VAL       polarity of selected bits in decoded_out / alloc_map
//   NUM_ENCODED_BITS  clog2(OUTPUT_WIDTH), index field width
//
//  Ports:
//   clk          in   1                    clock, rising edge
//   rst          in   1                    asynchronous reset, active low
//   clear        in   1                    synchronous clear of map/count/output
//   in_valid     in   1                    encoded_in valid
//   in_ready     out  1                    decoder can accept a code
//   encoded_in   in   NUM_ENCODED_BITS+1   MSB = active, low bits = index
//   out_valid    out  1                    decoded_out holds a new select
//   out_ready    in   1                    consumer takes decoded_out
//   decoded_out  out  OUTPUT_WIDTH         registered one-hot select
//   alloc_map    out  OUTPUT_WIDTH         cumulative allocated lanes
//   alloc_count  out  NUM_ENCODED_BITS+1   number of allocated lanes
//   map_full     out  1                    alloc_count == OUTPUT_WIDTH
//   err_dup      out  1                    pulse: index already allocated
//   err_range    out  1                    pulse: index >= OUTPUT_WIDTH
//
//  Build option SPARE_DECODER_ERR_CHECK_EN:
//   defined   -> duplicate and out-of-range codes are dropped and flagged on
//                err_dup / err_range for one cycle after the accepting edge.
//   undefined -> err_dup = err_range = 0; duplicates are re-issued on
//                decoded_out without touching the map or the count, and
//                out-of-range codes are dropped silently.
// -----------------------------------------------------------------------------
module spare_index_decoder
    import bisr_pkg::*;
#(
    parameter int  OUTPUT_WIDTH     = 4,
    parameter bit  DECODED_VAL      = 1'b1,
    localparam int NUM_ENCODED_BITS = bisr_clog2(OUTPUT_WIDTH)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NUM_ENCODED_BITS:0]   encoded_in,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [OUTPUT_WIDTH-1:0]     decoded_out,
    output logic [OUTPUT_WIDTH-1:0]     alloc_map,
    output logic [NUM_ENCODED_BITS:0]   alloc_count,
    output logic                        map_full,
    output logic                        err_dup,
    output logic                        err_range
);

    localparam int CNT_W      = NUM_ENCODED_BITS + 1;
    localparam int ACTIVE_POS = enc_active_pos(OUTPUT_WIDTH);

    localparam logic [CNT_W-1:0] COUNT_MAX = CNT_W'(OUTPUT_WIDTH);
    localparam logic [CNT_W-1:0] COUNT_ONE = CNT_W'(1);

    // Internally selects and the map are kept active-high; polarity is only
    // applied at the outputs.
    state_e                    state_q, state_d;
    logic                      rdy_en_q;
    logic                      out_valid_q, out_valid_d;
    logic [OUTPUT_WIDTH-1:0]   sel_q, sel_d;
    logic [OUTPUT_WIDTH-1:0]   map_q, map_d;
    logic [CNT_W-1:0]          count_q, count_d;

    logic                        code_active;
    logic [NUM_ENCODED_BITS-1:0] code_idx;
    logic [OUTPUT_WIDTH-1:0]     dec_onehot;
    logic [OUTPUT_WIDTH-1:0]     lane_sel;
    logic                        idx_out_of_range;
    logic                        dup_hit;
    logic                        accept;
    logic                        full_now;

`ifdef SPARE_DECODER_ERR_CHECK_EN
    logic err_dup_q, err_dup_d;
    logic err_range_q, err_range_d;
`endif

    assign code_active = encoded_in[ACTIVE_POS];
    assign code_idx    = encoded_in[ENC_IDX_LSB +: NUM_ENCODED_BITS];

    index_onehot_decoder #(
        .OUTPUT_WIDTH (OUTPUT_WIDTH),
        .DECODED_VAL  (DECODED_VAL),
        .IDX_W        (NUM_ENCODED_BITS)
    ) u_onehot (
        .idx_i       (code_idx),
        .onehot_o    (dec_onehot),
        .range_err_o (idx_out_of_range)
    );

    // Back to active-high regardless of DECODED_VAL. An out-of-range index
    // yields an all-zero select, so it can never touch the map.
    assign lane_sel = DECODED_VAL ? dec_onehot : ~dec_onehot;
    assign dup_hit  = |(lane_sel & map_q);

    assign full_now = (count_q == COUNT_MAX);

    // rdy_en_q keeps in_ready low while reset is held and for the cycle in
    // which it is released, independent of the (async-reset) FSM state.
    assign in_ready = rdy_en_q & (state_q == ST_IDLE) & ~full_now;
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        sel_d       = sel_q;
        map_d       = map_q;
        count_d     = count_q;
`ifdef SPARE_DECODER_ERR_CHECK_EN
        err_dup_d   = 1'b0;
        err_range_d = 1'b0;
`endif
        if (clear) begin
            // Clear beats any same-cycle accept and drops a pending output.
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            sel_d       = '0;
            map_d       = '0;
            count_d     = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (full_now) begin
                        // Only reached with out_valid already low.
                        state_d = ST_FULL;
                    end else if (accept && code_active) begin
                        if (idx_out_of_range) begin
`ifdef SPARE_DECODER_ERR_CHECK_EN
                            err_range_d = 1'b1;
`endif
                        end else if (dup_hit) begin
`ifdef SPARE_DECODER_ERR_CHECK_EN
                            err_dup_d   = 1'b1;
`else
                            // Re-issue the select; the lane is already counted.
                            sel_d       = lane_sel;
                            out_valid_d = 1'b1;
                            state_d     = ST_HOLD;
`endif
                        end else begin
                            sel_d       = lane_sel;
                            out_valid_d = 1'b1;
                            map_d       = map_q | lane_sel;
                            if (count_q != COUNT_MAX) begin
                                count_d = count_q + COUNT_ONE;
                            end
                            state_d     = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = ST_IDLE;
                    end
                end
                ST_FULL: begin
                    state_d = ST_FULL;
                end
                default: begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            rdy_en_q    <= 1'b0;
            out_valid_q <= 1'b0;
            sel_q       <= '0;
            map_q       <= '0;
            count_q     <= '0;
`ifdef SPARE_DECODER_ERR_CHECK_EN
            err_dup_q   <= 1'b0;
            err_range_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rdy_en_q    <= 1'b1;
            out_valid_q <= out_valid_d;
            sel_q       <= sel_d;
            map_q       <= map_d;
            count_q     <= count_d;
`ifdef SPARE_DECODER_ERR_CHECK_EN
            err_dup_q   <= err_dup_d;
            err_range_q <= err_range_d;
`endif
        end
    end

    assign out_valid   = out_valid_q;
    assign decoded_out = DECODED_VAL ? sel_q : ~sel_q;
    assign alloc_map   = DECODED_VAL ? map_q : ~map_q;
    assign alloc_count = count_q;
    assign map_full    = full_now;

`ifdef SPARE_DECODER_ERR_CHECK_EN
    assign err_dup   = err_dup_q;
    assign err_range = err_range_q;
`else
    assign err_dup   = 1'b0;
    assign err_range = 1'b0;
`endif

endmodule

// File: tb/tb_spare_index_decoder.sv
// -----------------------------------------------------------------------------
// tb_spare_index_decoder
//  Directed scenarios followed by randomized codes, checked against a lane
//  allocation model (array of claimed lanes). Six lanes so that indices 6 and 7
//  are out of range.
// -----------------------------------------------------------------------------
module tb_spare_index_decoder;

    localparam int W  = 6;
    localparam bit DV = 1'b1;
    localparam int NB = 3;
    localparam int EW = NB + 1;

`ifdef SPARE_DECODER_ERR_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk        = 1'b0;
    logic          rst        = 1'b0;
    logic          clear      = 1'b0;
    logic          in_valid   = 1'b0;
    logic          out_ready  = 1'b0;
    logic [EW-1:0] encoded_in = '0;
    logic          in_ready;
    logic          out_valid;
    logic [W-1:0]  decoded_out;
    logic [W-1:0]  alloc_map;
    logic [NB:0]   alloc_count;
    logic          map_full;
    logic          err_dup;
    logic          err_range;

    int n_checks = 0;
    int n_fail   = 0;
    int n_txn    = 0;

    bit alloc[W];

    always #5 clk = ~clk;

    spare_index_decoder #(
        .OUTPUT_WIDTH (W),
        .DECODED_VAL  (DV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .encoded_in  (encoded_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .decoded_out (decoded_out),
        .alloc_map   (alloc_map),
        .alloc_count (alloc_count),
        .map_full    (map_full),
        .err_dup     (err_dup),
        .err_range   (err_range)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int model_count();
        int c = 0;
        for (int i = 0; i < W; i++) c += int'(alloc[i]);
        return c;
    endfunction

    function automatic logic [W-1:0] model_map();
        logic [W-1:0] v;
        for (int i = 0; i < W; i++) v[i] = alloc[i] ? DV : !DV;
        return v;
    endfunction

    // Select pattern for lane idx; idx < 0 gives the idle (nothing selected) pattern.
    function automatic logic [W-1:0] lane_vec(input int idx);
        logic [W-1:0] v;
        for (int i = 0; i < W; i++) v[i] = (i == idx) ? DV : !DV;
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < W; i++) alloc[i] = 1'b0;
    endtask

    task automatic check_map(input string tag);
        check_eq({tag, "_map"},   alloc_map,   model_map());
        check_eq({tag, "_count"}, alloc_count, model_count());
        check_eq({tag, "_full"},  map_full,    model_count() == W);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_out_valid"},   out_valid,   0);
        check_eq({tag, "_decoded_out"}, decoded_out, lane_vec(-1));
        check_eq({tag, "_err_dup"},     err_dup,     0);
        check_eq({tag, "_err_range"},   err_range,   0);
        check_map(tag);
    endtask

    // Entered and left at #1 after a rising edge.
    task automatic do_clear(input bit with_code);
        logic [EW-1:0] code;
        code  = {1'b1, NB'(1)};
        clear = 1'b1;
        if (with_code) begin
            in_valid   = 1'b1;
            encoded_in = code;
        end
        @(posedge clk); #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        model_reset();
        check_idle_outputs("clear");
        check_eq("clear_in_ready", in_ready, 1);
        $display("txn %0d clear (with_code=%0b)", n_txn, with_code);
        n_txn++;
    endtask

    task automatic do_async_reset();
        rst = 1'b0;
        #1;
        model_reset();
        check_idle_outputs("rst");
        check_eq("rst_in_ready_low", in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        check_eq("rst_release_in_ready", in_ready, 0);
        @(posedge clk); #1;
        check_eq("rst_after_in_ready", in_ready, 1);
        $display("txn %0d async reset", n_txn);
        n_txn++;
    endtask

    // action: 0 = release with out_ready, 1 = clear while holding, 2 = reset while holding
    task automatic send_code(input bit active, input int idx, input int hold, input int action);
        logic [NB-1:0] ix;
        logic [EW-1:0] code;
        bit exp_valid, exp_dup, exp_rng;
        ix   = idx[NB-1:0];
        code = {active, ix};
        exp_valid = 1'b0;
        exp_dup   = 1'b0;
        exp_rng   = 1'b0;

        if (model_count() == W) begin
            // Full map: the code must be stalled.
            in_valid   = 1'b1;
            encoded_in = code;
            for (int k = 0; k < 4; k++) begin
                @(posedge clk); #1;
                check_eq("stall_in_ready", in_ready, 0);
                check_eq("stall_out_valid", out_valid, 0);
                check_map("stall");
            end
            in_valid = 1'b0;
            $display("txn %0d code=%b stalled (map full)", n_txn, code);
            n_txn++;
            return;
        end

        check_eq("in_ready_idle", in_ready, 1);
        if (in_ready !== 1'b1) return;

        in_valid   = 1'b1;
        encoded_in = code;
        @(posedge clk); #1;
        in_valid = 1'b0;

        if (active) begin
            if (idx >= W) begin
                exp_rng = ERR_EN;
            end else if (alloc[idx]) begin
                if (ERR_EN) exp_dup = 1'b1;
                else        exp_valid = 1'b1;
            end else begin
                alloc[idx] = 1'b1;
                exp_valid  = 1'b1;
            end
        end

        check_eq("out_valid", out_valid, exp_valid);
        check_eq("err_dup",   err_dup,   exp_dup);
        check_eq("err_range", err_range, exp_rng);
        check_map("accept");

        if (exp_valid) begin
            check_eq("decoded_out", decoded_out, lane_vec(idx));
            for (int k = 0; k < hold; k++) begin
                check_eq("hold_in_ready", in_ready, 0);
                @(posedge clk); #1;
                check_eq("hold_out_valid", out_valid, 1);
                check_eq("hold_decoded", decoded_out, lane_vec(idx));
            end
            if (action == 1) begin
                do_clear(1'b0);
            end else if (action == 2) begin
                do_async_reset();
            end else begin
                out_ready = 1'b1;
                @(posedge clk); #1;
                out_ready = 1'b0;
                check_eq("release_out_valid", out_valid, 0);
            end
        end else begin
            @(posedge clk); #1;
            check_eq("pulse_end_dup",   err_dup,   0);
            check_eq("pulse_end_range", err_range, 0);
            check_eq("drop_out_valid",  out_valid, 0);
        end
        $display("txn %0d code=%b valid=%0b dup=%0b rng=%0b count=%0d",
                 n_txn, code, exp_valid, exp_dup, exp_rng, model_count());
        n_txn++;
    endtask

    initial begin
        int r;
        model_reset();

        // Reset state while rst is held.
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        check_eq("reset_in_ready", in_ready, 0);
        rst = 1'b1;
        check_eq("release_in_ready", in_ready, 0);
        @(posedge clk); #1;
        check_eq("post_reset_in_ready", in_ready, 1);

        // Basic decode, duplicate, out-of-range, inactive.
        send_code(1'b1, 2, 0, 0);
        send_code(1'b1, 2, 0, 0);
        send_code(1'b1, 7, 0, 0);
        send_code(1'b1, 6, 0, 0);
        send_code(1'b0, 3, 0, 0);
        // Long hold with out_ready low.
        send_code(1'b1, 0, 5, 0);
        // Fill the map, then a stalled code, then clear in FULL.
        send_code(1'b1, 1, 1, 0);
        send_code(1'b1, 3, 0, 0);
        send_code(1'b1, 4, 2, 0);
        send_code(1'b1, 5, 0, 0);
        send_code(1'b1, 1, 0, 0);
        do_clear(1'b0);
        // Clear in HOLD, reset in HOLD, clear colliding with an accept.
        send_code(1'b1, 4, 2, 1);
        send_code(1'b1, 5, 1, 2);
        send_code(1'b1, 3, 0, 0);
        do_clear(1'b1);

        // Randomized codes.
        for (int t = 0; t < 150; t++) begin
            if (model_count() == W) begin
                send_code(1'b1, int'($urandom_range(0, 7)), 0, 0);
                do_clear($urandom_range(0, 1) == 1);
            end else begin
                r = int'($urandom_range(0, 19));
                send_code($urandom_range(0, 7) != 0,
                          int'($urandom_range(0, 7)),
                          int'($urandom_range(0, 3)),
                          (r == 0) ? 1 : ((r == 1) ? 2 : 0));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
